// File: rtl/fp_mul_mantissa_iter.sv
// Sequential FP32 mantissa multiplier and result packer.
// It computes a radix-2 shift-add product with one multiplier bit per cycle
// (24 cycles), then normalizes and rounds to nearest-even in a single cycle.
// It packs the IEEE-754 single result and hands it off with valid/ready.
module fp_mul_mantissa_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] mul1_mantissa_normalized,
    input  logic [23:0] mul2_mantissa_normalized,
    input  logic [4:0]  mul1_shift,
    input  logic [4:0]  mul2_shift,
    input  logic [7:0]  current_exponent,
    input  logic        result_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  count;

    logic [23:0] multiplicand;
    logic [23:0] multiplier;
    logic [47:0] product;
    logic [4:0]  shift1;
    logic [4:0]  shift2;
    logic [7:0]  exponent;
    logic        sign;

    logic        accept;
    logic [33:0] packed_nxt;

    // Normalize the 48-bit product, round to nearest-even, and apply the
    // zero / overflow / underflow exceptions in priority order.
    // Returned as {overflow, underflow, result[31:0]}.
    function automatic logic [33:0] norm_round(
        input logic [47:0] p,
        input logic [7:0]  exp_in,
        input logic [4:0]  sh1,
        input logic [4:0]  sh2,
        input logic        sgn
    );
        logic signed [10:0] e;
        logic [22:0]        mant;
        logic               guard;
        logic               sticky;
        logic [23:0]        mant_rnd;
        logic [33:0]        res;
        e = $signed({3'b000, exp_in}) - $signed({6'b000000, sh1})
            - $signed({6'b000000, sh2}) + $signed({10'b0000000000, p[47]});
        if (p[47]) begin
            mant   = p[46:24];
            guard  = p[23];
            sticky = |p[22:0];
        end else begin
            mant   = p[45:23];
            guard  = p[22];
            sticky = |p[21:0];
        end
        mant_rnd = {1'b0, mant} + {23'b0, (guard && (sticky || mant[0]))};
        // A carry out of the fraction leaves it all-zero and bumps the exponent.
        if (mant_rnd[23]) begin
            e = e + 11'sd1;
        end
        if (p == 48'd0) begin
            res = {2'b00, sgn, 31'b0};
        end else if (e >= 11'sd255) begin
            res = {2'b10, sgn, 8'hFF, 23'b0};
        end else if (e <= 11'sd0) begin
            res = {2'b01, sgn, 31'b0};
        end else begin
            res = {2'b00, sgn, e[7:0], mant_rnd[22:0]};
        end
        return res;
    endfunction

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign packed_nxt = norm_round(product, exponent, shift1, shift2, sign);

    // Next-state logic: fixed 24 multiply iterations, one normalize cycle,
    // then hold the result until downstream takes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = MUL;
            MUL:  if (count == 5'd23) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 5'd0;
            out_valid <= 1'b0;
            result    <= 32'h0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                count <= 5'd0;
            end else if (state == MUL) begin
                count <= count + 5'd1;
            end
            if (state == NORM) begin
                out_valid <= 1'b1;
                overflow  <= packed_nxt[33];
                underflow <= packed_nxt[32];
                result    <= packed_nxt[31:0];
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Operand capture and shift-add datapath; these need no reset because
    // they are always reloaded on accept before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            multiplicand <= mul1_mantissa_normalized;
            multiplier   <= mul2_mantissa_normalized;
            shift1       <= mul1_shift;
            shift2       <= mul2_shift;
            exponent     <= current_exponent;
            sign         <= result_sign;
            product      <= 48'd0;
        end else if (state == MUL) begin
            if (multiplier[0]) begin
                product <= product + ({24'd0, multiplicand} << count);
            end
            multiplier <= multiplier >> 1;
        end
    end

endmodule

// File: tb/tb_fp_mul_mantissa_iter.sv
// Scoreboard bench for fp_mul_mantissa_iter: directed cases plus randomized
// operands against an arithmetic reference model.
module tb_fp_mul_mantissa_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] mul1_mantissa_normalized = '0;
    logic [23:0] mul2_mantissa_normalized = '0;
    logic [4:0]  mul1_shift = '0;
    logic [4:0]  mul2_shift = '0;
    logic [7:0]  current_exponent = '0;
    logic        result_sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    always #5 clk = ~clk;

    fp_mul_mantissa_iter dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .mul1_mantissa_normalized (mul1_mantissa_normalized),
        .mul2_mantissa_normalized (mul2_mantissa_normalized),
        .mul1_shift               (mul1_shift),
        .mul2_shift               (mul2_shift),
        .current_exponent         (current_exponent),
        .result_sign              (result_sign),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .result                   (result),
        .overflow                 (overflow),
        .underflow                (underflow)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   ready_mode = 1;   // 0: random out_ready, 1: tied high, 2: driven by the test

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    endtask

    // Reference: exact integer product, normalize by magnitude, round half-even
    // using the remainder compared against one half ulp.
    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                   input logic [4:0] s1, input logic [4:0] s2,
                                   input logic [7:0] e, input logic sg);
        exp_t r;
        longint unsigned p, q, rem, half;
        int ex, sh;
        r.acc = 0; r.ovf = 1'b0; r.unf = 1'b0;
        p  = 64'(a) * 64'(b);
        ex = int'(e) - int'(s1) - int'(s2);
        if (p >= (64'd1 << 47)) begin sh = 24; ex++; end
        else sh = 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q >= (64'd1 << 24)) begin q = q >> 1; ex++; end
        if (p == 0) r.res = {sg, 31'b0};
        else if (ex >= 255) begin r.res = {sg, 8'hFF, 23'b0}; r.ovf = 1'b1; end
        else if (ex <= 0) begin r.res = {sg, 31'b0}; r.unf = 1'b1; end
        else r.res = {sg, 8'(ex), q[22:0]};
        return r;
    endfunction

    // Random backpressure, applied only when the test asks for it.
    initial forever begin
        @(posedge clk); #3;
        if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else if (ready_mode == 1) out_ready = 1'b1;
    end

    // Present one operand set, wait (bounded) for acceptance, push the expectation.
    task automatic do_op(input logic [23:0] a, input logic [23:0] b, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [7:0] e, input logic sg);
        exp_t x;
        bit   ok;
        ok = 1'b0;
        @(posedge clk); #2;
        mul1_mantissa_normalized = a; mul2_mantissa_normalized = b;
        mul1_shift = s1; mul2_shift = s2; current_exponent = e; result_sign = sg;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL accept_timeout: in_ready never rose, required 1");
        end else begin
            x = model(a, b, s1, s2, e, sg);
            x.acc = cyc;
            sbq.push_back(x);
        end
        mul1_mantissa_normalized = 24'($urandom);
        mul2_mantissa_normalized = 24'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: latency, value and flag checks, plus handshake-hold behaviour.
    initial begin
        bit          prev_v = 1'b0;
        bit          hs_prev = 1'b0;
        logic [31:0] prev_res = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0; hs_prev = 1'b0;
            end else begin
                if (hs_prev) chk("valid_drop", {31'b0, out_valid}, 32'd0);
                if (prev_v && !hs_prev) begin
                    chk("hold_valid", {31'b0, out_valid}, 32'd1);
                    chk("hold_result", result, prev_res);
                end
                if (out_valid) begin
                    chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
                    if (!prev_v || hs_prev) begin
                        if (sbq.size() == 0) begin
                            checks++;
                            $display("FAIL unexpected_output: got %h, required none", result);
                        end else begin
                            chk("latency", 32'(cyc - sbq[0].acc), 32'd25);
                            chk("result", result, sbq[0].res);
                            chk("flags", {30'b0, overflow, underflow}, {30'b0, sbq[0].ovf, sbq[0].unf});
                        end
                    end
                    if (out_ready && sbq.size() != 0) void'(sbq.pop_front());
                end
                hs_prev  = out_valid && out_ready;
                prev_v   = out_valid;
                prev_res = result;
            end
        end
    end

    initial begin
        logic [23:0] ra, rb;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {30'b0, overflow, underflow}, 32'd0);
        rst_n = 1'b1;

        ready_mode = 1;
        do_op(24'hC00000, 24'h800000, 5'd0, 5'd0, 8'd128, 1'b0);   // 1.5 x 2.0
        drain();
        do_op(24'h800001, 24'hC00000, 5'd0, 5'd0, 8'd127, 1'b0);   // tie to even, round up
        drain();
        do_op(24'hC00000, 24'hC00000, 5'd0, 5'd0, 8'd254, 1'b0);   // overflow
        drain();
        do_op(24'h800000, 24'h800000, 5'd2, 5'd0, 8'd1, 1'b1);     // underflow
        drain();

        // Zero operand held under backpressure; a stray in_valid must be ignored.
        ready_mode = 2;
        @(posedge clk); #2;
        out_ready = 1'b0;
        do_op(24'h000000, 24'hC00000, 5'd0, 5'd0, 8'd127, 1'b1);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            in_valid = (i == 3);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        @(posedge clk); #2;
        chk("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of the multiply loop.
        ready_mode = 1;
        do_op(24'hC00000, 24'h800000, 5'd0, 5'd0, 8'd128, 1'b0);
        drain();
        do_op(24'hA00000, 24'hE00000, 5'd0, 5'd0, 8'd127, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_result", result, 32'h0);
        chk("midrst_flags", {30'b0, overflow, underflow}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        do_op(24'hC00000, 24'h800000, 5'd0, 5'd0, 8'd128, 1'b0);
        drain();

        // Randomized operands with random backpressure.
        ready_mode = 0;
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 15) == 0) ? 24'h0 : {1'b1, 23'($urandom)};
            rb = ($urandom_range(0, 15) == 0) ? 24'h0 : {1'b1, 23'($urandom)};
            if (n % 5 == 0) rb = 24'hC00000;   // exposes exact half-ulp ties
            do_op(ra, rb, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                  8'($urandom_range(0, 255)), 1'($urandom));
        end
        drain();
        ready_mode = 1;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
